// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port (video=p0, cpu=p1) arbiter in front of an SRAM controller.
// Define SRAM_ARB_FAIR_EN to promote port 1 after MAX_WAIT denied cycles.
module sram_arbiter #(
  parameter int AW       = 18,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            p0_req,
  input  logic            p0_we,
  input  logic [AW-1:0]   p0_addr,
  input  logic [DW-1:0]   p0_wdata,
  input  logic [DW/8-1:0] p0_strobe,
  output logic            p0_gnt,
  output logic            p0_rvalid,
  output logic [DW-1:0]   p0_rdata,
  input  logic            p1_req,
  input  logic            p1_we,
  input  logic [AW-1:0]   p1_addr,
  input  logic [DW-1:0]   p1_wdata,
  input  logic [DW/8-1:0] p1_strobe,
  output logic            p1_gnt,
  output logic            p1_rvalid,
  output logic [DW-1:0]   p1_rdata,
  output logic            m_read,
  output logic            m_write,
  output logic [AW-1:0]   m_address,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_strobe,
  input  logic [DW-1:0]   m_rdata
);

  localparam int SW = DW / 8;

  if (DW != 16 || MAX_WAIT < 1) begin : g_bad_cfg
    $error("sram_arbiter: DW must be 16 and MAX_WAIT >= 1");
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strobe;
  } req_t;

  req_t sel;
  logic any_gnt;
  logic promote;
  logic pend;
  logic pend_own;

`ifdef SRAM_ARB_FAIR_EN
  localparam int CW =
    ($clog2(MAX_WAIT + 1) < 3) ? 3 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;

  assign promote = (wait_cnt == CW'(MAX_WAIT));

  // Counts consecutive denied cycles; saturates once promotion is armed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!p1_req || p1_gnt) begin
      wait_cnt <= '0;
    end else if (!promote) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end
`else
  assign promote = 1'b0;
`endif

  assign p0_gnt  = rst_n & p0_req & ~(promote & p1_req);
  assign p1_gnt  = rst_n & p1_req & (~p0_req | promote);
  assign any_gnt = p0_gnt | p1_gnt;

  always_comb begin
    sel = '0;
    unique case (1'b1)
      p0_gnt:  sel = {p0_we, p0_addr, p0_wdata, p0_strobe};
      p1_gnt:  sel = {p1_we, p1_addr, p1_wdata, p1_strobe};
      default: sel = '0;
    endcase
  end

  assign m_read    = any_gnt & ~sel.we;
  assign m_write   = any_gnt & sel.we;
  assign m_address = sel.addr;
  assign m_wdata   = sel.wdata;
  assign m_strobe  = sel.strobe;

  // Controller data is valid one cycle after m_read; owner travels with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      pend_own  <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      pend      <= m_read;
      pend_own  <= p1_gnt;
      p0_rvalid <= pend & ~pend_own;
      p1_rvalid <= pend & pend_own;
      if (pend && !pend_own) begin
        p0_rdata <= m_rdata;
      end
      if (pend && pend_own) begin
        p1_rdata <= m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scenarios then randomized traffic for sram_arbiter,
// checked every cycle against a cycle-level reference of the arbitration rules.
module tb_sram_arbiter;

  localparam int AW       = 18;
  localparam int DW       = 16;
  localparam int MAX_WAIT = 4;
`ifdef SRAM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p0_req = 1'b0, p0_we = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic [1:0]    p0_strobe = '0;
  logic          p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic [1:0]    p1_strobe = '0;
  logic [DW-1:0] m_rdata = '0;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          m_read, m_write;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_wdata;
  logic [1:0]    m_strobe;

  sram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_strobe(p0_strobe),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_strobe(p1_strobe),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .m_read(m_read), .m_write(m_write), .m_address(m_address),
    .m_wdata(m_wdata), .m_strobe(m_strobe), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference: who won, which read is awaiting data, what each port holds.
  int            ref_starve = 0;
  int            ref_pend   = -1;
  bit            ref_rv0 = 1'b0, ref_rv1 = 1'b0;
  logic [DW-1:0] ref_rd0 = '0, ref_rd1 = '0;
  int            win = -1;
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [1:0]    e_strobe;

  logic          s_p0_gnt, s_p1_gnt, s_p0_rv, s_p1_rv, s_mr, s_mw;
  logic [AW-1:0] s_ma;
  logic [DW-1:0] s_mwd, s_p0_rd, s_p1_rd;
  logic [1:0]    s_ms;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    if (!rst_n) return -1;
    if (p0_req && p1_req)
      return (FAIR && ref_starve >= MAX_WAIT) ? 1 : 0;
    if (p0_req) return 0;
    if (p1_req) return 1;
    return -1;
  endfunction

  task automatic tick();
    @(negedge clk);
    win      = pick();
    e_we     = (win == 0) ? p0_we     : (win == 1) ? p1_we     : 1'b0;
    e_addr   = (win == 0) ? p0_addr   : (win == 1) ? p1_addr   : '0;
    e_wdata  = (win == 0) ? p0_wdata  : (win == 1) ? p1_wdata  : '0;
    e_strobe = (win == 0) ? p0_strobe : (win == 1) ? p1_strobe : '0;
    s_p0_gnt = p0_gnt;  s_p1_gnt = p1_gnt;
    s_p0_rv  = p0_rvalid; s_p1_rv = p1_rvalid;
    s_p0_rd  = p0_rdata;  s_p1_rd = p1_rdata;
    s_mr = m_read; s_mw = m_write;
    s_ma = m_address; s_mwd = m_wdata; s_ms = m_strobe;
    chk("p0_gnt", 32'(s_p0_gnt), 32'(win == 0));
    chk("p1_gnt", 32'(s_p1_gnt), 32'(win == 1));
    chk("m_read", 32'(s_mr), 32'(win >= 0 && !e_we));
    chk("m_write", 32'(s_mw), 32'(win >= 0 && e_we));
    chk("m_address", 32'(s_ma), 32'(e_addr));
    chk("m_wdata", 32'(s_mwd), 32'(e_wdata));
    chk("m_strobe", 32'(s_ms), 32'(e_strobe));
    chk("p0_rvalid", 32'(s_p0_rv), 32'(ref_rv0));
    chk("p1_rvalid", 32'(s_p1_rv), 32'(ref_rv1));
    chk("p0_rdata", 32'(s_p0_rd), 32'(ref_rd0));
    chk("p1_rdata", 32'(s_p1_rd), 32'(ref_rd1));
    @(posedge clk);
    if (!rst_n) begin
      ref_starve = 0; ref_pend = -1;
      ref_rv0 = 1'b0; ref_rv1 = 1'b0;
      ref_rd0 = '0;   ref_rd1 = '0;
    end else begin
      ref_rv0 = (ref_pend == 0);
      ref_rv1 = (ref_pend == 1);
      if (ref_pend == 0) ref_rd0 = m_rdata;
      if (ref_pend == 1) ref_rd1 = m_rdata;
      ref_pend   = (win >= 0 && !e_we) ? win : -1;
      ref_starve = (p1_req && win != 1) ? ref_starve + 1 : 0;
    end
    #1;
  endtask

  task automatic idle();
    p0_req = 1'b0; p1_req = 1'b0;
  endtask

  logic [9:0] gmask;
  int         cnt;

  initial begin
    // Reset with both ports requesting: nothing may be granted.
    p0_req = 1'b1; p1_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tick();
    chk("rst_gnt", 32'(s_p0_gnt | s_p1_gnt | s_mr | s_mw), 32'd0);
    tick();
    chk("rst_rvalid", 32'(s_p0_rv | s_p1_rv), 32'd0);
    rst_n = 1'b1; idle();
    tick();

    // Lone p1 read; data returned one cycle later, rvalid two later.
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 18'h00010;
    tick();
    chk("p1_alone_gnt", 32'(s_p1_gnt), 32'd1);
    chk("p1_alone_addr", 32'(s_ma), 32'h10);
    idle(); m_rdata = 16'h1234;
    tick();
    m_rdata = 16'h5555;
    tick();
    chk("p1_alone_rv", 32'(s_p1_rv), 32'd1);
    chk("p1_alone_rd", 32'(s_p1_rd), 32'h1234);
    chk("p1_alone_p0rv", 32'(s_p0_rv), 32'd0);
    tick();

    // Contention: p0 first, then p1; returns in grant order.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 18'h00AAA;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 18'h00BBB;
    tick();
    chk("both_p0gnt", 32'(s_p0_gnt), 32'd1);
    chk("both_p1gnt", 32'(s_p1_gnt), 32'd0);
    p0_req = 1'b0; m_rdata = 16'hA0A0;
    tick();
    chk("next_p1gnt", 32'(s_p1_gnt), 32'd1);
    chk("next_addr", 32'(s_ma), 32'hBBB);
    p1_req = 1'b0; m_rdata = 16'hB1B1;
    tick();
    chk("order_p0rv", 32'(s_p0_rv), 32'd1);
    chk("order_p0rd", 32'(s_p0_rd), 32'hA0A0);
    chk("order_p1rv_early", 32'(s_p1_rv), 32'd0);
    m_rdata = 16'h0F0F;
    tick();
    chk("order_p1rv", 32'(s_p1_rv), 32'd1);
    chk("order_p1rd", 32'(s_p1_rd), 32'hB1B1);

    // Write at top address, then read; exactly one p0 rvalid.
    cnt = 0;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 18'h3FFFF;
    p0_wdata = 16'hBEEF; p0_strobe = 2'b10;
    tick();
    chk("wr_mwrite", 32'(s_mw), 32'd1);
    chk("wr_mread", 32'(s_mr), 32'd0);
    chk("wr_addr", 32'(s_ma), 32'h3FFFF);
    chk("wr_data", 32'(s_mwd), 32'hBEEF);
    chk("wr_strobe", 32'(s_ms), 32'h2);
    cnt += int'(s_p0_rv);
    p0_we = 1'b0;
    tick();
    chk("rd_mread", 32'(s_mr), 32'd1);
    chk("rd_mwrite", 32'(s_mw), 32'd0);
    cnt += int'(s_p0_rv);
    idle(); m_rdata = 16'hC3C3;
    for (int i = 0; i < 4; i++) begin
      tick();
      cnt += int'(s_p0_rv);
      m_rdata = 16'($urandom);
    end
    chk("wr_rd_rvcount", 32'(cnt), 32'd1);

    // Sustained contention: fairness pattern or strict p0 priority.
    gmask = '0;
    p0_req = 1'b1; p0_we = 1'b0; p1_req = 1'b1; p1_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      m_rdata = 16'($urandom);
      p0_addr = AW'($urandom);
      if (s_p1_gnt) p1_addr = AW'($urandom);
      tick();
      gmask[i] = s_p1_gnt;
    end
    chk("fair_pattern", 32'(gmask), FAIR ? 32'h210 : 32'h0);
    idle();
    tick();
    tick();

    // Reset right after a p1 read grant discards the return.
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 18'h01234;
    tick();
    chk("flush_gnt", 32'(s_p1_gnt), 32'd1);
    idle(); rst_n = 1'b0; p1_req = 1'b1; m_rdata = 16'h7777;
    tick();
    chk("flush_rst_gnt", 32'(s_p1_gnt | s_mr), 32'd0);
    idle(); rst_n = 1'b1;
    tick();
    chk("flush_allzero", 32'(s_p0_gnt | s_p1_gnt | s_p0_rv | s_p1_rv |
        s_mr | s_mw | (|s_ma) | (|s_mwd) | (|s_ms) |
        (|s_p0_rd) | (|s_p1_rd)), 32'd0);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 18'h00042;
    tick();
    chk("flush_p1rv", 32'(s_p1_rv), 32'd0);
    chk("post_rst_p0gnt", 32'(s_p0_gnt), 32'd1);
    idle();
    tick();

    // Random traffic; a denied requester holds its request stable.
    for (int i = 0; i < 500; i++) begin
      rst_n = ($urandom_range(0, 60) != 0);
      if (!p0_req || win == 0) begin
        p0_req    = 1'($urandom_range(0, 1));
        p0_we     = 1'($urandom);
        p0_addr   = AW'($urandom);
        p0_wdata  = 16'($urandom);
        p0_strobe = 2'($urandom);
      end
      if (!p1_req || win == 1) begin
        p1_req    = 1'($urandom_range(0, 1));
        p1_we     = 1'($urandom);
        p1_addr   = AW'($urandom);
        p1_wdata  = 16'($urandom);
        p1_strobe = 2'($urandom);
      end
      m_rdata = 16'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter AW, default 18, word-address width toward the SRAM controller.
REQ-002 Parameter DW, default 16, data width; only 16 is supported.
REQ-003 Parameter MAX_WAIT, default 4, consecutive denied cycles before port 1 is promoted (fair mode only).
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 p0_req / p1_req  input  1  port request valid (port 0 = video fetch, port 1 = CPU).
REQ-007 p0_we / p1_we  input  1  1 = write, 0 = read.
REQ-008 p0_addr / p1_addr  input  AW  word address.
REQ-009 p0_wdata / p1_wdata  input  DW  write data.
REQ-010 p0_strobe / p1_strobe  input  DW/8  byte enables.
REQ-011 p0_gnt / p1_gnt  output  1  combinational accept; a transfer occurs when req and gnt are both high.
REQ-012 p0_rvalid / p1_rvalid  output  1  one-cycle pulse, read data valid.
REQ-013 p0_rdata / p1_rdata  output  DW  registered read data, held until the next read return to that port.
REQ-014 m_read, m_write  output  1  request to the SRAM controller.
REQ-015 m_address  output  AW; m_wdata  output  DW; m_strobe  output  DW/8.
REQ-016 m_rdata  input  DW  controller read data, valid the cycle after m_read.

Function
REQ-017 At most one gnt SHALL be high per cycle; gnt is 0 for a port whose req is 0.
REQ-018 Default priority: port 0 over port 1 when both request.
REQ-019 m_read = granted req and not we; m_write = granted req and we; m_address, m_wdata and m_strobe SHALL mux from the granted port, and are 0 when idle.
REQ-020 On a read accepted in cycle N, the block SHALL record the owner and a pending flag; in cycle N+1 it SHALL capture m_rdata into that port's rdata register; rvalid for that port SHALL pulse in cycle N+2.
REQ-021 Back-to-back reads SHALL be accepted every cycle; the return pipeline is 2 deep with no stalls, and returns stay in order.
REQ-022 A write produces no rvalid; rdata registers SHALL be unchanged by writes.
REQ-023 Reads and writes from either port may interleave cycle by cycle with no idle cycle inserted.
REQ-024 Non-granted requests SHALL wait; the requester holds req and its payload stable until gnt.
REQ-025 A port whose req is low SHALL not affect the other port's grant or its starvation counter.

Reset
REQ-026 While rst_n = 0, both gnt outputs, m_read and m_write SHALL be 0.
REQ-027 While rst_n = 0, pending flags, both rvalid outputs and the starvation counter SHALL clear to 0, and rdata registers SHALL clear to 0.
REQ-028 Reads in flight when reset asserts SHALL be discarded: no rvalid after reset.

Configuration
REQ-029 With macro SRAM_ARB_FAIR_EN defined, a 3-bit-minimum counter SHALL count cycles in which p1_req = 1 and p1_gnt = 0. The counter SHALL clear on a p1 grant or when p1_req = 0. When the counter equals MAX_WAIT, port 1 SHALL win the next contention, then the counter clears.
REQ-030 Without SRAM_ARB_FAIR_EN, priority SHALL be strictly fixed (port 0 always wins) and no counter logic is present.

Verification
REQ-031 p1 read addr 0x00010 alone, m_rdata = 0x1234 in cycle N+1 -> p1_gnt in cycle N, p1_rvalid in cycle N+2, p1_rdata = 0x1234, p0_rvalid stays 0.
REQ-032 p0 and p1 request reads in the same cycle -> p0_gnt = 1, p1_gnt = 0. Next cycle, with p0_req low -> p1_gnt = 1, and returns arrive in grant order.
REQ-033 p0 write addr 0x3FFFF, data 0xBEEF, strobe 2'b10, then p0 read in the next cycle -> m_write, then m_read, on consecutive cycles with correct muxed fields, and exactly one p0_rvalid.
REQ-034 SRAM_ARB_FAIR_EN defined, MAX_WAIT = 4, p0 and p1 requesting continuously -> p0 is granted 4 cycles, p1 on the 5th, and the pattern repeats. Without the macro -> p1 is never granted.
REQ-035 rst_n asserted in the cycle after a p1 read grant -> no p1_rvalid, all outputs 0, and normal operation on the first cycle after release.
